pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter width in bits (≥4).
REQ-002 SHALL have parameter BAMT_W, default 8, branch-offset width (≤PC_W), two's-complement.
REQ-003 SHALL have parameter NUM_PROGS, default 3, number of selectable programs (1..8).
REQ-004 SHALL have parameter PROG_BASE, default {0,25,44}, array of NUM_PROGS start addresses, each PC_W bits.
REQ-005 SHALL have parameter STACK_DEPTH, default 4, return-stack entries (1..16).
REQ-006 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port op  input  5  current opcode, encodings from package definitions.
REQ-009 SHALL have port z, lt  input  1 each  ALU zero / less-than flags for the current op.
REQ-010 SHALL have port bamt  input  BAMT_W  signed branch/call offset.
REQ-011 SHALL have port start  input  1  single-cycle pulse launching the next program.
REQ-012 SHALL have port stall  input  1  hold PC and stack this cycle.
REQ-013 SHALL have port PC  output  PC_W  instruction address.
REQ-014 SHALL have port prog_idx  output  clog2(NUM_PROGS)  index of the program launched next.
REQ-015 SHALL have port running, done, fault  output  1 each  RUN state / one-cycle HALT pulse / FAULT state.
REQ-016 SHALL have port sp  output  clog2(STACK_DEPTH+1)  current stack occupancy.

Function
REQ-017 SHALL implement states IDLE, RUN, FAULT; running=1 only in RUN, fault=1 only in FAULT.
REQ-018 In any state, start SHALL load PC=PROG_BASE[prog_idx], set sp=0, increment prog_idx modulo NUM_PROGS, enter RUN next cycle; start has highest priority.
REQ-019 In IDLE and FAULT without start, PC, sp, prog_idx SHALL hold.
REQ-020 In RUN with stall=1 and no start, all state SHALL hold; op is ignored.
REQ-021 In RUN, taken = op==BA | (op==BL & lt) | (op==BG & !lt) | (op==BE & z); taken SHALL set PC = PC + sign-extended bamt, modulo 2^PC_W.
REQ-022 In RUN, op==CALL with sp<STACK_DEPTH SHALL push PC+1 (mod 2^PC_W), increment sp, set PC = PC + sext(bamt).
REQ-023 In RUN, op==RET with sp>0 SHALL pop top entry into PC and decrement sp.
REQ-024 CALL at sp==STACK_DEPTH or RET at sp==0 SHALL enter FAULT with PC and sp unchanged.
REQ-025 In RUN, op==HALT SHALL hold PC, enter IDLE, and assert done for exactly the following cycle.
REQ-026 All other ops and not-taken branches SHALL set PC = PC+1, wrapping 2^PC_W-1 -> 0.
REQ-027 Outputs SHALL be registered; PC reflects a decision one cycle after op is presented.
REQ-028 Stack contents beyond sp SHALL be don't-care; no read of an empty stack SHALL alter PC.

Reset
REQ-029 Reset low SHALL immediately force PC=0, prog_idx=0, sp=0, state IDLE, done=0, regardless of clk.
REQ-030 Reset asserted mid-program SHALL discard the stack; release SHALL leave block in IDLE awaiting start.

Structure
REQ-031 Opcodes BA, BL, BG, BE, CALL, RET, HALT and enum pc_state_t {IDLE, RUN, FAULT} SHALL live in package definitions.
REQ-032 The return stack SHALL be sub-module ret_stack (parameters PC_W, STACK_DEPTH; push, pop, din, dout, sp); pc_seq owns the FSM and PC arithmetic.

Verification (PC_W=8, BAMT_W=8, PROG_BASE={0,25,44}, STACK_DEPTH=4)
REQ-033 Reset, start x4 separated by HALT -> PC loads 0, 25, 44, 0; prog_idx 1,2,0,1; done one cycle after each HALT.
REQ-034 From PC=30: BE z=1 bamt=-5 -> PC=25; BL lt=0 bamt=10 -> PC=26; BA bamt=0x7F at PC=0xF0 -> PC=0x6F (wrap).
REQ-035 At PC=10: CALL bamt=20 -> PC=30, sp=1; RET -> PC=11, sp=0; 4 nested CALLs then 5th CALL -> FAULT, PC and sp=4 unchanged.
REQ-036 RET at sp=0 -> FAULT; then start -> RUN at next PROG_BASE with sp=0.
REQ-037 stall=1 for 3 cycles with BA presented -> PC unchanged; stall and start same cycle -> start wins.
REQ-038 Reset asserted asynchronously between clk edges mid-CALL chain -> PC=0, sp=0, IDLE before next edge.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - opcode encodings and sequencer state type shared by pc_seq and its bench
package definitions;

    localparam int OP_W = 5;

    // Opcodes the sequencer reacts to; every other encoding just advances the PC
    localparam logic [OP_W-1:0] NOP  = 5'd0;
    localparam logic [OP_W-1:0] BA   = 5'd1;
    localparam logic [OP_W-1:0] BL   = 5'd2;
    localparam logic [OP_W-1:0] BG   = 5'd3;
    localparam logic [OP_W-1:0] BE   = 5'd4;
    localparam logic [OP_W-1:0] CALL = 5'd5;
    localparam logic [OP_W-1:0] RET  = 5'd6;
    localparam logic [OP_W-1:0] HALT = 5'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_seq_ret_stack.sv
// rtl/pc_seq_ret_stack.sv - LIFO of return addresses with registered occupancy
module ret_stack #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4,
    localparam int SP_W       = $clog2(STACK_DEPTH + 1),
    localparam int AW         = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic [SP_W-1:0] sp
);

    logic [PC_W-1:0] mem [0:(2**AW)-1];
    logic [SP_W-1:0] sp_q;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;

    // sp never exceeds STACK_DEPTH <= 2**AW, so the low bits address the slot and
    // wrapping subtraction on those bits still lands on sp-1 for any non-empty stack
    assign wr_idx = sp_q[AW-1:0];
    assign rd_idx = wr_idx - AW'(1);
    assign sp     = sp_q;

    // An empty stack reads as zero so a stray pop can never inject stale data
    assign dout = (sp_q != '0) ? mem[rd_idx] : '0;

    // Entry storage needs no reset: anything at or above sp is don't-care
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= din;
        end
    end

    // Occupancy counter; clear (program launch) overrides push/pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q <= '0;
        end else if (clear) begin
            sp_q <= '0;
        end else if (push) begin
            sp_q <= sp_q + SP_W'(1);
        end else if (pop) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program counter sequencer with branches, call/return stack and program launch
module pc_seq
    import definitions::*;
#(
    parameter int PC_W        = 8,
    parameter int BAMT_W      = 8,
    parameter int NUM_PROGS   = 3,
    parameter logic [PC_W-1:0] PROG_BASE [NUM_PROGS] = '{8'd0, 8'd25, 8'd44},
    parameter int STACK_DEPTH = 4,
    localparam int IDX_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
    localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OP_W-1:0]   op,
    input  logic              z,
    input  logic              lt,
    input  logic [BAMT_W-1:0] bamt,
    input  logic              start,
    input  logic              stall,
    output logic [PC_W-1:0]   PC,
    output logic [IDX_W-1:0]  prog_idx,
    output logic              running,
    output logic              done,
    output logic              fault,
    output logic [SP_W-1:0]   sp
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PROGS - 1);
    localparam logic [SP_W-1:0]  SP_FULL  = SP_W'(STACK_DEPTH);

    pc_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic            done_q, done_d;

    logic            push, pop, clear;
    logic [PC_W-1:0] stack_dout;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_br;
    logic            taken;

    ret_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stack_dout),
        .sp    (sp)
    );

    // Both targets wrap modulo 2**PC_W; the offset is sign-extended to PC width
    assign pc_inc = pc_q + PC_W'(1);
    assign pc_br  = pc_q + PC_W'($signed(bamt));
    assign taken  = (op == BA) | ((op == BL) & lt) | ((op == BG) & ~lt) | ((op == BE) & z);

    // State, PC, program index and done pulse all update together on the clock edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Next-state decode: start beats everything, stall freezes RUN, stack misuse faults
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        if (start) begin
            pc_d    = PROG_BASE[idx_q];
            clear   = 1'b1;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            state_d = RUN;
        end else if (state_q == RUN && !stall) begin
            case (op)
                CALL: begin
                    if (sp < SP_FULL) begin
                        push = 1'b1;
                        pc_d = pc_br;
                    end else begin
                        state_d = FAULT;
                    end
                end
                RET: begin
                    if (sp != '0) begin
                        pop  = 1'b1;
                        pc_d = stack_dout;
                    end else begin
                        state_d = FAULT;
                    end
                end
                HALT: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: begin
                    pc_d = taken ? pc_br : pc_inc;
                end
            endcase
        end
    end

    assign PC       = pc_q;
    assign prog_idx = idx_q;
    assign done     = done_q;
    assign running  = (state_q == RUN);
    assign fault    = (state_q == FAULT);

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - directed self-checking bench for pc_seq
module tb_pc_seq;
    import definitions::*;

    logic        clk;
    logic        reset;
    logic [4:0]  op;
    logic        z;
    logic        lt;
    logic [7:0]  bamt;
    logic        start;
    logic        stall;
    logic [7:0]  PC;
    logic [1:0]  prog_idx;
    logic        running;
    logic        done;
    logic        fault;
    logic [2:0]  sp;

    int checks = 0;
    int errors = 0;

    pc_seq dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .z        (z),
        .lt       (lt),
        .bamt     (bamt),
        .start    (start),
        .stall    (stall),
        .PC       (PC),
        .prog_idx (prog_idx),
        .running  (running),
        .done     (done),
        .fault    (fault),
        .sp       (sp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for one cycle, then sample just after the edge
    task automatic do_op(input logic [4:0] o, input logic zz, input logic ll, input logic [7:0] b);
        op = o; z = zz; lt = ll; bamt = b; start = 1'b0; stall = 1'b0;
        step();
        op = NOP;
    endtask

    task automatic do_start();
        op = NOP; start = 1'b1; stall = 1'b0;
        step();
        start = 1'b0;
    endtask

    task automatic expect_st(input string tag, input logic [7:0] epc, input logic [2:0] esp,
                             input logic erun, input logic efault);
        check({tag, "_pc"}, 32'(PC), 32'(epc));
        check({tag, "_sp"}, 32'(sp), 32'(esp));
        check({tag, "_run"}, 32'(running), 32'(erun));
        check({tag, "_fault"}, 32'(fault), 32'(efault));
    endtask

    logic [7:0] base_exp [4];
    logic [1:0] idx_exp  [4];

    initial begin
        base_exp = '{8'd0, 8'd25, 8'd44, 8'd0};
        idx_exp  = '{2'd1, 2'd2, 2'd0, 2'd1};
        op = NOP; z = 0; lt = 0; bamt = 0; start = 0; stall = 0;

        // asynchronous reset before the first clock edge
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        expect_st("rst", 8'd0, 3'd0, 1'b0, 1'b0);
        check("rst_idx", 32'(prog_idx), 0);
        check("rst_done", 32'(done), 0);
        #1 reset = 1'b1;

        // four launches separated by HALT
        for (int i = 0; i < 4; i++) begin
            do_start();
            expect_st($sformatf("launch%0d", i), base_exp[i], 3'd0, 1'b1, 1'b0);
            check($sformatf("launch%0d_idx", i), 32'(prog_idx), 32'(idx_exp[i]));
            do_op(HALT, 0, 0, 8'd0);
            check($sformatf("halt%0d_done", i), 32'(done), 1);
            check($sformatf("halt%0d_pc", i), 32'(PC), 32'(base_exp[i]));
            check($sformatf("halt%0d_run", i), 32'(running), 0);
            step();
            check($sformatf("idle%0d_done", i), 32'(done), 0);
            check($sformatf("idle%0d_pc", i), 32'(PC), 32'(base_exp[i]));
        end
        // relaunch program 1 (index now 1 -> base 25); walk back to PC=0 via BA
        do_start();
        check("relaunch_pc", 32'(PC), 25);
        do_op(BA, 0, 0, 8'hE7);                 // 25 - 25 = 0
        check("ba_to0", 32'(PC), 0);

        // call / return and conditional branches
        do_op(BA, 0, 0, 8'd10);
        check("ba10", 32'(PC), 10);
        do_op(CALL, 0, 0, 8'd20);
        expect_st("call1", 8'd30, 3'd1, 1'b1, 1'b0);
        do_op(BE, 1, 0, 8'hFB);
        check("be_taken", 32'(PC), 25);
        do_op(BL, 0, 0, 8'd10);
        check("bl_not", 32'(PC), 26);
        do_op(RET, 0, 0, 8'd0);
        expect_st("ret1", 8'd11, 3'd0, 1'b1, 1'b0);
        do_op(BG, 0, 0, 8'd2);
        check("bg_taken", 32'(PC), 13);
        do_op(BL, 0, 1, 8'd3);
        check("bl_taken", 32'(PC), 16);
        do_op(BE, 0, 0, 8'd9);
        check("be_not", 32'(PC), 17);
        do_op(BG, 0, 1, 8'd9);
        check("bg_not", 32'(PC), 18);
        do_op(BA, 0, 0, 8'hDE);                 // 18 - 34 = -16 -> 0xF0
        check("ba_neg", 32'(PC), 32'hF0);
        do_op(BA, 0, 0, 8'h7F);
        check("ba_wrap", 32'(PC), 32'h6F);
        do_op(BA, 0, 0, 8'h90);                 // 0x6F - 112 = 0xFF
        check("ba_ff", 32'(PC), 32'hFF);
        do_op(5'd17, 0, 0, 8'd0);
        check("inc_wrap", 32'(PC), 0);

        // nested calls up to full stack, then overflow
        for (int i = 1; i <= 4; i++) begin
            do_op(CALL, 0, 0, 8'd4);
            expect_st($sformatf("ncall%0d", i), 8'(4 * i), 3'(i), 1'b1, 1'b0);
        end
        do_op(RET, 0, 0, 8'd0);
        expect_st("nret", 8'd13, 3'd3, 1'b1, 1'b0);
        do_op(CALL, 0, 0, 8'd4);
        expect_st("recall", 8'd17, 3'd4, 1'b1, 1'b0);
        do_op(CALL, 0, 0, 8'd4);
        expect_st("overflow", 8'd17, 3'd4, 1'b0, 1'b1);
        do_op(BA, 0, 0, 8'd4);
        expect_st("fault_hold", 8'd17, 3'd4, 1'b0, 1'b1);
        do_start();
        expect_st("fault_start", 8'd44, 3'd0, 1'b1, 1'b0);
        check("fault_start_idx", 32'(prog_idx), 0);

        // underflow
        do_op(RET, 0, 0, 8'd0);
        expect_st("underflow", 8'd44, 3'd0, 1'b0, 1'b1);
        do_start();
        expect_st("uf_start", 8'd0, 3'd0, 1'b1, 1'b0);
        check("uf_start_idx", 32'(prog_idx), 1);

        // stall holds everything for three cycles
        do_op(BA, 0, 0, 8'd40);
        check("pre_stall", 32'(PC), 40);
        op = BA; bamt = 8'd5; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall%0d_pc", i), 32'(PC), 40);
        end
        op = HALT;
        step();
        check("stall_halt_run", 32'(running), 1);
        check("stall_halt_done", 32'(done), 0);
        start = 1'b1;
        step();
        start = 1'b0; stall = 1'b0;
        expect_st("stall_start", 8'd25, 3'd0, 1'b1, 1'b0);
        check("stall_start_idx", 32'(prog_idx), 2);

        // async reset between edges in the middle of a call chain
        do_op(CALL, 0, 0, 8'd3);
        do_op(CALL, 0, 0, 8'd3);
        expect_st("chain", 8'd31, 3'd2, 1'b1, 1'b0);
        op = CALL; bamt = 8'd3;
        #2 reset = 1'b0;
        #1;
        expect_st("async_rst", 8'd0, 3'd0, 1'b0, 1'b0);
        check("async_rst_idx", 32'(prog_idx), 0);
        check("async_rst_done", 32'(done), 0);
        step();
        #1 reset = 1'b1;
        step();
        expect_st("post_rst", 8'd0, 3'd0, 1'b0, 1'b0);
        op = NOP;
        do_start();
        expect_st("post_rst_start", 8'd0, 3'd0, 1'b1, 1'b0);
        check("post_rst_idx", 32'(prog_idx), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
